counter_updown_param: RTL
=========================

# counter_updown_param

Parametrised up/down/step counter with parallel load, selectable wrap or saturate on overflow, and registered ripple-carry and load-strobe outputs. It generalises the fixed 4-bit mode counter to any width and step size and adds saturation. It sits in the datapath wherever a loadable event or position counter is needed. Its `rco` output is intended to drive the `enable` of a following stage for cascading.

## Interface
- `WIDTH`, 8, counter width in bits; legal range 2..32.
- `STEP`, 3, increment used in mode 10; legal range 1..2^WIDTH-1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable`  in  1  count qualifier for modes 00/01/10; ignored by mode 11.
- `mode`  in  2  00 = up by 1, 01 = down by 1, 10 = up by STEP, 11 = parallel load of `D`.
- `sat`  in  1  0 = wrap modulo 2^WIDTH; 1 = clamp at the boundary.
- `D`  in  WIDTH  parallel load value.
- `Q`  out  WIDTH  registered count.
- `rco`  out  1  registered overflow/underflow strobe.
- `load`  out  1  registered load strobe.

## Operation
- All outputs are flops; there is no combinational path from input to output.
- Reset (async assert, sync-safe deassert by the system) forces `Q`=0, `rco`=0 and `load`=0.
- Mode 11: `Q` <= `D` on every clock, regardless of `enable` and `sat`. Next cycle: `load`=1, `rco`=0.
- Modes 00/01/10 with `enable`=0: `Q` holds; `rco`=0 and `load`=0 next cycle.
- Modes 00/01/10 with `enable`=1:
  - The result is computed at WIDTH+1 bits. Up: `Q` + inc, with inc = 1 (mode 00) or STEP (mode 10). Down: `Q` − 1.
  - Overflow: the sum's carry bit is 1. Underflow: `Q`==0 in mode 01.
  - On overflow/underflow with `sat`=0: `Q` <= low WIDTH bits of the result (wrap).
  - On overflow with `sat`=1: `Q` <= all-ones.
  - On underflow with `sat`=1: `Q` <= 0.
  - `rco` = 1 next cycle whenever overflow/underflow occurred, independent of `sat`. While saturated and still enabled, `rco` stays 1 every cycle, because each cycle overflows again.
  - Without overflow/underflow: `Q` <= result, `rco`=0.
  - `load`=0.
- Mode changes take effect on the next clock; there is no pipeline or history beyond `Q`.
- `sat` is sampled each clock and may change at any time.

## Timing
- Latency: one clock from input sampling to the `Q`/`rco`/`load` update.
- `rco` and `load` are single-cycle strobes aligned with the `Q` value they describe. Example: `Q` wraps to 0 in the same cycle that `rco`=1.
- Cascading: `rco` of stage N drives `enable` of stage N+1. Stage N+1 then advances one clock after stage N wraps (the registered carry adds one cycle of skew per stage).
- Reset asserted mid-count clears outputs within the same cycle, with no clock required. The first count after reset release occurs on the first rising edge with `reset`=0.
- `reset` and mode 11 in the same cycle: reset wins.

## Test plan
(WIDTH=4, STEP=3 unless noted.)
- Reset: drive `Q`=9 via load, then assert `reset` between clock edges -> `Q`=0, `rco`=0, `load`=0 immediately; hold for 3 clocks with no change.
- Up wrap: load 14, mode 00, `enable`=1, `sat`=0 -> `Q`=15 (`rco` 0), then `Q`=0 with `rco`=1, then `Q`=1 with `rco`=0.
- Step saturate: load 10, mode 10, `sat`=1 -> `Q`=13, then 15 with `rco`=1, then 15 with `rco`=1. Switch `sat`=0 -> `Q`=2 with `rco`=1.
- Down underflow: load 1, mode 01 -> `Q`=0, then 15 with `rco`=1. Repeat with `sat`=1 -> holds at 0 with `rco`=1 each cycle.
- Load/enable: mode 11, `D`=7, `enable`=0 -> `Q`=7 and `load`=1 one cycle. Mode 00, `enable`=0 -> `Q` stays 7, `load`=0, `rco`=0.
- Cascade: two instances, stage-0 `rco` feeding stage-1 `enable`, mode 00 on both, 40 enabled clocks from 0 -> stage-0 `Q`=8, stage-1 `Q`=2. Stage-1 increments exactly one clock after each stage-0 wrap.

Source files
------------

// File: rtl/counter_updown_param_if.sv
// Control and status bundle for counter_updown_param.
// Handshake: this bus has no valid/ready pair. The counter samples enable,
// mode, sat and D on every rising clock edge, and Q/rco/load are always
// valid registered values that describe the most recent edge.
interface counter_updown_param_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [1:0]       mode;
  logic             sat;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             rco;
  logic             load;

  // The side that issues count/load commands.
  modport master (
    output enable, mode, sat, D,
    input  Q, rco, load
  );

  // The counter itself.
  modport slave (
    input  enable, mode, sat, D,
    output Q, rco, load
  );
endinterface

// File: rtl/counter_updown_param.sv
// Parametrised up/down/step counter with parallel load, wrap or saturate
// on overflow, and registered carry (rco) and load strobes. rco is meant
// to feed the enable of a following stage when counters are cascaded.
module counter_updown_param #(
  parameter int WIDTH = 8,
  parameter int STEP  = 3
) (
  input  logic clk,
  input  logic reset,
  counter_updown_param_if.slave bus
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Increments carried at WIDTH+1 bits so the top bit is the carry out.
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] q_r;
  logic             rco_r;
  logic             load_r;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ovf;
  logic             unf;
  logic [WIDTH-1:0] q_next;
  logic             rco_next;
  logic             load_next;

  assign bus.Q    = q_r;
  assign bus.rco  = rco_r;
  assign bus.load = load_r;

  // Next count and strobes; load ignores enable and sat, underflow is
  // only possible when counting down from zero.
  always_comb begin
    sum       = {1'b0, q_r} + ((bus.mode == MODE_STEP) ? STEP_EXT : ONE_EXT);
    diff      = {1'b0, q_r} - ONE_EXT;
    ovf       = 1'b0;
    unf       = 1'b0;
    q_next    = q_r;
    rco_next  = 1'b0;
    load_next = 1'b0;
    if (bus.mode == MODE_LOAD) begin
      q_next    = bus.D;
      load_next = 1'b1;
    end else if (bus.enable) begin
      if (bus.mode == MODE_DOWN) begin
        unf    = (q_r == '0);
        q_next = (unf && bus.sat) ? '0 : diff[WIDTH-1:0];
      end else begin
        // MODE_UP and MODE_STEP differ only in the increment chosen above.
        ovf    = sum[WIDTH];
        q_next = (ovf && bus.sat) ? '1 : sum[WIDTH-1:0];
      end
      rco_next = ovf | unf;
    end
  end

  // Count register and strobes; reset clears everything without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= '0;
      rco_r  <= 1'b0;
      load_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      rco_r  <= rco_next;
      load_r <= load_next;
    end
  end

  // MODE_UP is named for readability of the mode map; keep it referenced.
  logic mode_is_up;
  assign mode_is_up = (bus.mode == MODE_UP);
  logic unused_ok;
  assign unused_ok = mode_is_up;

endmodule
